fpext_share_arb: RTL
====================

Name: fpext_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one pipelined single-to-double float-extension core between NREQ requesters.
- Accepts 32-bit operands over per-requester valid/ready, issues one per cycle into the core via its clock-enable, and tracks requester IDs through a valid/ID shadow pipeline.
- Returns each 64-bit result on a single valid/ready result port tagged with the originating requester.
- Sits between HLS-generated kernel loops and the fpext core instance. The core is external; this block drives its ce/din0 and reads its dout.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, equals clog2(NREQ)
- LAT, 2, core latency in ce-qualified cycles from din0 capture to matching dout (must be >= 1)
- DIN_W, 32, operand width
- DOUT_W, 64, result width

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_data  in  NREQ*DIN_W  packed operands; requester i at [i*DIN_W +: DIN_W]
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_data  out  DOUT_W  extended result
- res_id  out  IDW  requester index of res_data
- flush  in  1  synchronous: kill all in-flight ops and reset round-robin pointer
- core_ce  out  1  core clock-enable
- core_din  out  DIN_W  core operand
- core_dout  in  DOUT_W  core result
- busy  out  1  any op in flight or result pending

Behaviour:
- Reset (reset_n=0, async): shadow valid bits=0, rr pointer=0, res_valid=0, req_ready=0, busy=0, core_ce=0.
  - The first cycle after release behaves as idle.
- Stall: stall = tail_valid & ~res_ready; core_ce = ~stall.
  - While stalled, the core and shadow pipeline hold, and core dout holds (core guarantees this under ce=0).
- Arbitration (combinational, per cycle): if core_ce=1 and flush=0, grant the first requester with req_valid set.
  - Search starts at rr_ptr and wraps modulo NREQ.
  - req_ready[g]=1 only for the granted requester; transfer = req_valid & req_ready.
  - core_din = req_data[g]. When there is no grant, core_din = 0.
- rr_ptr update: on transfer, rr_ptr <= g+1 mod NREQ, with wrap from NREQ-1 to 0. No transfer leaves it unchanged.
- Shadow pipeline: LAT stages of {valid, id}, advanced only when core_ce=1.
  - Stage0 loads {transfer, g}; stage k loads stage k-1.
  - tail = stage LAT-1.
- Result: res_valid = tail_valid; res_data = core_dout; res_id = tail_id. These outputs are combinational from registered state and core output.
  - A result completes when res_valid & res_ready.
  - Result held for multiple cycles: res_data/res_id stay stable while res_valid=1 and res_ready=0.
- Throughput: one op per cycle with no bubbles when res_ready is held high.
  - Latency from req transfer to res_valid is exactly LAT cycles with no stalls; each stalled cycle adds one.
- Simultaneous transfer + completion in one cycle is legal and required (pipeline advances).
- Stall + new request: no grant and req_ready=0. The requester must hold its data (AXI-style).
- flush: all shadow valids <= 0 and rr_ptr <= 0 on the next edge; no grant is issued in the flush cycle.
  - Any result presented in the flush cycle is dropped even if res_ready=1. The consumer must ignore res_valid during flush.
- busy = OR of shadow valid bits.
- Reset mid-operation: all in-flight ops are lost and no res_valid is issued for them. Core contents are don't-care because the shadow valids are cleared.
- Ordering: results return in issue order, globally and per requester.

Decomposition:
- Package fpext_share_pkg: localparams DIN_W/DOUT_W defaults, a function clog2, and a typedef for a shadow entry {valid, id}.
- One sub-module, rr_arbiter (NREQ req/grant, enable, rr pointer update), reusable across shared-unit controllers.
- Shadow pipeline is a generate loop in the top.

Test Plan:
- Single request: req_valid=4'b0010, data 0x3F800000, res_ready=1 -> req_ready=4'b0010 one cycle. After LAT=2 cycles: res_valid=1, res_id=1, res_data=0x3FF0000000000000.
- All four requesting continuously with res_ready=1 -> grants in order 0,1,2,3,0,… (wraps). One result per cycle, ids 0,1,2,3 in order. No gaps after the initial 2-cycle fill.
- Backpressure: stream 3 ops, hold res_ready=0 for 5 cycles once res_valid rises -> core_ce=0, req_ready=0, res_data/res_id stable. All 3 results are delivered in order after release, with no loss or duplication.
- rr fairness: requester 0 always valid, requester 3 valid from cycle 2 -> requester 3 is granted within 4 cycles, not starved.
- flush with 2 ops in flight -> busy=0 and res_valid=0 next cycle. The next grant goes to the lowest-indexed valid requester (rr_ptr=0).
- Async reset asserted mid-stream, between clock edges -> res_valid, req_ready, core_ce and busy go to 0 immediately. No stale result appears after reset release.

Source files
------------

// File: rtl/fpext_share_pkg.sv
// Shared definitions for the fpext sharing controller.
//   DIN_W_DEF / DOUT_W_DEF : default operand and result widths
//   ID_MAX_W               : widest requester ID carried in a shadow entry (NREQ <= 8)
//   clog2()                : constant ceil(log2) helper for parameter defaults
//   shadow_t               : one shadow pipeline entry {valid, id}
package fpext_share_pkg;

  localparam int DIN_W_DEF  = 32;
  localparam int DOUT_W_DEF = 64;
  localparam int ID_MAX_W   = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // The id field is sized for the largest supported NREQ; narrower
  // configurations zero-extend on entry and truncate at the tail.
  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } shadow_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal rotating priority pointer.
//   clk, rst_n   : clock, asynchronous active-low reset
//   en           : arbitration allowed this cycle (no grant when low)
//   clr          : synchronous pointer clear back to requester 0
//   req          : per-requester request vector
//   grant        : one-hot grant (or zero)
//   grant_idx    : index of the granted requester
//   grant_valid  : a grant was issued this cycle
// A grant always implies a transfer here because grants are only issued
// to requesters that are asserting req, so the pointer advances on grant.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   idx;

  // Search starts at ptr_q and wraps modulo N; first hit wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int i = 0; i < N; i++) begin
      idx = {1'b0, ptr_q} + (IW+1)'(i);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (en && !grant_valid && req[idx[IW-1:0]]) begin
        grant_valid           = 1'b1;
        grant_idx             = idx[IW-1:0];
        grant[idx[IW-1:0]]    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (grant_valid) begin
      ptr_d = (grant_idx == IW'(N-1)) ? '0 : grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fpext_share_arb.sv
// Shares one pipelined float->double extension core among NREQ requesters.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/ready/data  : per-requester operand handshake (data packed, i at [i*DIN_W +: DIN_W])
//   res_valid/ready/data  : single result handshake, res_id tags the originating requester
//   flush                 : kill all in-flight ops and reset round-robin priority
//   core_ce/din/dout      : drive/observe the external core (LAT ce-cycles latency)
//   busy                  : any op in flight or result pending
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high; a source keeps valid and data stable until that happens, and ready
// may depend combinationally on valid.
module fpext_share_arb
  import fpext_share_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int IDW    = clog2(NREQ),
  parameter int LAT    = 2,
  parameter int DIN_W  = DIN_W_DEF,
  parameter int DOUT_W = DOUT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*DIN_W-1:0] req_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DOUT_W-1:0]     res_data,
  output logic [IDW-1:0]        res_id,
  input  logic                  flush,
  output logic                  core_ce,
  output logic [DIN_W-1:0]      core_din,
  input  logic [DOUT_W-1:0]     core_dout,
  output logic                  busy
);

  shadow_t shadow_q [LAT];
  shadow_t shadow_d [LAT];
  shadow_t stage_in [LAT];
  shadow_t tail;

  logic           stall;
  logic           arb_en;
  logic [IDW-1:0] grant_idx;
  logic           grant_valid;

  assign tail  = shadow_q[LAT-1];
  assign stall = tail.valid & ~res_ready;
  // Gated by reset_n so the core and requesters see a quiet interface
  // while reset is held, not just after the next edge.
  assign core_ce = reset_n & ~stall;
  assign arb_en  = core_ce & ~flush;

  rr_arbiter #(
    .N  (NREQ),
    .IW (IDW)
  ) u_arb (
    .clk         (clk),
    .rst_n       (reset_n),
    .en          (arb_en),
    .clr         (flush),
    .req         (req_valid),
    .grant       (req_ready),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    core_din = '0;
    if (grant_valid) core_din = req_data[grant_idx*DIN_W +: DIN_W];
  end

  // Stage inputs: stage 0 takes the new issue, later stages shift.
  for (genvar k = 0; k < LAT; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign stage_in[k] = '{valid: grant_valid, id: ID_MAX_W'(grant_idx)};
    end else begin : g_body
      assign stage_in[k] = shadow_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < LAT; k++) begin
      shadow_d[k] = shadow_q[k];
      if (core_ce) shadow_d[k] = stage_in[k];
      if (flush)   shadow_d[k].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < LAT; k++) shadow_q[k] <= '0;
    end else begin
      for (int k = 0; k < LAT; k++) shadow_q[k] <= shadow_d[k];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LAT; k++) busy = busy | shadow_q[k].valid;
  end

  assign res_valid = tail.valid;
  assign res_data  = core_dout;
  assign res_id    = tail.id[IDW-1:0];

endmodule
